// File: rtl/input_buffer_router.sv
// NoC router input stage: DRTS/CTS ingress FIFO, XY route of header flit, held one-hot request to arbiters.
// Optional feature: define IBUF_DROP_ORPHAN_EN to discard non-header flits seen in IDLE and flag err.
module input_buffer_router #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int COORD_W    = 2,
  parameter int CUR_X      = 0,
  parameter int CUR_Y      = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] RX,
  input  logic                  DRTS,
  output logic                  CTS,
  input  logic                  Grant_N,
  input  logic                  Grant_E,
  input  logic                  Grant_W,
  input  logic                  Grant_S,
  input  logic                  Grant_L,
  output logic [DATA_WIDTH-1:0] Data_out,
  output logic                  empty,
  output logic                  Req_N,
  output logic                  Req_E,
  output logic                  Req_W,
  output logic                  Req_S,
  output logic                  Req_L,
  output logic                  err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [2:0] T_HDR  = 3'b001;
  localparam logic [2:0] T_TAIL = 3'b100;
  localparam logic [COORD_W-1:0] CX = COORD_W'(CUR_X);
  localparam logic [COORD_W-1:0] CY = COORD_W'(CUR_Y);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  // Request vector bit order: {N, E, W, S, L}
  localparam logic [4:0] R_N = 5'b10000;
  localparam logic [4:0] R_E = 5'b01000;
  localparam logic [4:0] R_W = 5'b00100;
  localparam logic [4:0] R_S = 5'b00010;
  localparam logic [4:0] R_L = 5'b00001;

  typedef enum logic {IDLE, BUSY} state_t;

  logic [DEPTH-1:0][DATA_WIDTH-1:0] mem;
  logic [AW-1:0]          rd_ptr, wr_ptr;
  logic [AW:0]            count;
  state_t                 state;
  logic [4:0]             req;
  logic [4:0]             route;
  logic [DATA_WIDTH-1:0]  head;
  logic [2:0]             head_type;
  logic [COORD_W-1:0]     dest_x, dest_y;
  logic                   grant_any, wr_en, pop_grant, drop, pop;

  assign head      = mem[rd_ptr];
  assign head_type = head[DATA_WIDTH-1 -: 3];
  assign dest_x    = head[COORD_W-1:0];
  assign dest_y    = head[2*COORD_W-1:COORD_W];

  assign Data_out  = head;
  assign empty     = (count == '0);
  assign grant_any = Grant_N | Grant_E | Grant_W | Grant_S | Grant_L;
  // CTS gating keeps one accept per handshake while upstream still holds DRTS.
  assign wr_en     = DRTS && !CTS && (count < FULL_CNT);
  assign pop_grant = grant_any && !empty && (state == BUSY);

`ifdef IBUF_DROP_ORPHAN_EN
  assign drop = (state == IDLE) && !empty && (head_type != T_HDR);
`else
  assign drop = 1'b0;
`endif

  assign pop = pop_grant || drop;

  // XY routing: resolve X first, then Y (Y grows southward).
  always_comb begin
    route = R_L;
    if (dest_x > CX)      route = R_E;
    else if (dest_x < CX) route = R_W;
    else if (dest_y > CY) route = R_S;
    else if (dest_y < CY) route = R_N;
  end

  // Storage is deliberately not reset; only pointers/count define validity.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= RX;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      CTS    <= 1'b0;
    end else begin
      CTS <= wr_en;
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      req   <= '0;
    end else begin
      case (state)
        IDLE: if (!empty && head_type == T_HDR) begin
          req   <= route;
          state <= BUSY;
        end
        BUSY: if (pop_grant && head_type == T_TAIL) begin
          req   <= '0;
          state <= IDLE;
        end
        default: begin
          req   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign {Req_N, Req_E, Req_W, Req_S, Req_L} = req;

`ifdef IBUF_DROP_ORPHAN_EN
  logic err_q;
  always_ff @(posedge clk) begin
    if (!rst)      err_q <= 1'b0;
    else if (drop) err_q <= 1'b1;
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_input_buffer_router.sv
// Self-checking bench for input_buffer_router: route table plus handshake/packet corner sequences.
module tb_input_buffer_router;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [DW-1:0] RX = '0;
  logic          DRTS = 1'b0;
  logic          CTS;
  logic [4:0]    gnt = '0;
  logic [DW-1:0] Data_out;
  logic          empty;
  logic          Req_N, Req_E, Req_W, Req_S, Req_L;
  logic          err;
  logic [4:0]    req;

  input_buffer_router #(.DATA_WIDTH(DW), .DEPTH(4), .COORD_W(2), .CUR_X(1), .CUR_Y(1)) dut (
    .clk(clk), .rst(rst), .RX(RX), .DRTS(DRTS), .CTS(CTS),
    .Grant_N(gnt[4]), .Grant_E(gnt[3]), .Grant_W(gnt[2]), .Grant_S(gnt[1]), .Grant_L(gnt[0]),
    .Data_out(Data_out), .empty(empty),
    .Req_N(Req_N), .Req_E(Req_E), .Req_W(Req_W), .Req_S(Req_S), .Req_L(Req_L),
    .err(err)
  );

  assign req = {Req_N, Req_E, Req_W, Req_S, Req_L};
  always #5 clk = ~clk;

  localparam logic [4:0] N = 5'b10000, E = 5'b01000, W = 5'b00100, S = 5'b00010, L = 5'b00001;

  typedef struct {
    logic [1:0] dx;
    logic [1:0] dy;
    logic [4:0] exp_req;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;
  logic [DW-1:0] sb[$];

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] hdr(input logic [1:0] dx, input logic [1:0] dy, input int tag);
    logic [24:0] pl;
    pl = 25'(tag);
    return {3'b001, pl, dy, dx};
  endfunction

  function automatic logic [DW-1:0] body(input int tag);
    logic [28:0] pl;
    pl = 29'(tag);
    return {3'b010, pl};
  endfunction

  function automatic logic [DW-1:0] tail(input int tag);
    logic [28:0] pl;
    pl = 29'(tag);
    return {3'b100, pl};
  endfunction

  // Returns just after the accepting edge's CTS has been observed.
  task automatic send_flit(input logic [DW-1:0] f, input bit push);
    int n = 0;
    DRTS = 1'b1;
    RX   = f;
    do begin
      @(posedge clk); #1; n++;
    end while (!CTS && n < 40);
    chk("cts_accept", {31'b0, CTS}, 1);
    DRTS = 1'b0;
    if (push && CTS) sb.push_back(f);
  endtask

  task automatic pop_one(input string nm, input logic [4:0] g);
    logic [DW-1:0] exp;
    @(negedge clk);
    chk({nm, "_nonempty"}, {31'b0, empty}, 0);
    if (sb.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: got %0h expected scoreboard entry", nm, Data_out);
    end else begin
      exp = sb.pop_front();
      chk(nm, Data_out, exp);
    end
    gnt = g;
    @(posedge clk); #1;
    gnt = '0;
  endtask

  task automatic do_reset();
    DRTS = 1'b0;
    gnt  = '0;
    rst  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    sb.delete();
  endtask

  vec_t tbl[8];
  bit   seen;

  initial begin
    tbl[0] = '{2'd3, 2'd1, E};
    tbl[1] = '{2'd0, 2'd1, W};
    tbl[2] = '{2'd1, 2'd2, S};
    tbl[3] = '{2'd1, 2'd0, N};
    tbl[4] = '{2'd1, 2'd1, L};
    tbl[5] = '{2'd2, 2'd3, E};
    tbl[6] = '{2'd0, 2'd0, W};
    tbl[7] = '{2'd1, 2'd3, S};

    // Reset state, sampled while reset is still applied
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_empty", {31'b0, empty}, 1);
    chk("rst_cts",   {31'b0, CTS}, 0);
    chk("rst_req",   {27'b0, req}, 0);
    chk("rst_err",   {31'b0, err}, 0);
    rst = 1'b1;

    // Routing table: header -> one-cycle-later request, then tail releases it
    for (int i = 0; i < 8; i++) begin
      send_flit(hdr(tbl[i].dx, tbl[i].dy, i + 1), 1);
      chk("hdr_not_empty", {31'b0, empty}, 0);
      chk("req_latency",   {27'b0, req}, 0);
      @(posedge clk); #1;
      chk($sformatf("route_%0d", i), {27'b0, req}, {27'b0, tbl[i].exp_req});
      chk("cts_one_cycle", {31'b0, CTS}, 0);
      send_flit(tail(i + 1), 1);
      pop_one("tbl_hdr", tbl[i].exp_req);
      chk("req_held", {27'b0, req}, {27'b0, tbl[i].exp_req});
      pop_one("tbl_tail", tbl[i].exp_req);
      chk("req_released", {27'b0, req}, 0);
      chk("tbl_empty", {31'b0, empty}, 1);
    end

    // 3-flit packet to N
    send_flit(hdr(2'd1, 2'd0, 100), 1);
    send_flit(body(101), 1);
    send_flit(tail(102), 1);
    chk("pkt3_req", {27'b0, req}, {27'b0, N});
    pop_one("pkt3_h", N);
    pop_one("pkt3_b", N);
    chk("pkt3_req_hold", {27'b0, req}, {27'b0, N});
    pop_one("pkt3_t", N);
    chk("pkt3_req_drop", {27'b0, req}, 0);
    chk("pkt3_empty", {31'b0, empty}, 1);

    // Fill, blocked 5th write, pop frees a slot, 5th lands at wrapped index 0
    send_flit(hdr(2'd1, 2'd1, 200), 1);
    send_flit(body(201), 1);
    send_flit(body(202), 1);
    send_flit(body(203), 1);
    DRTS = 1'b1;
    RX   = tail(204);
    seen = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (CTS) seen = 1'b1;
    end
    chk("full_no_cts", {31'b0, seen}, 0);
    chk("full_req", {27'b0, req}, {27'b0, L});
    pop_one("fill_h", L);
    chk("cts_not_same_edge", {31'b0, CTS}, 0);
    @(posedge clk); #1;
    chk("cts_after_free", {31'b0, CTS}, 1);
    DRTS = 1'b0;
    sb.push_back(tail(204));
    @(posedge clk); #1;
    chk("cts_pulse_end", {31'b0, CTS}, 0);
    pop_one("fill_b1", L);
    pop_one("fill_b2", L);
    pop_one("fill_b3", L);
    pop_one("fill_wrap_t", L);
    chk("fill_req_drop", {27'b0, req}, 0);
    chk("fill_empty", {31'b0, empty}, 1);

    // Back-to-back packets: L then W, one dead cycle between requests
    send_flit(hdr(2'd1, 2'd1, 300), 1);
    send_flit(tail(301), 1);
    send_flit(hdr(2'd0, 2'd1, 302), 1);
    send_flit(tail(303), 1);
    chk("b2b_req_l", {27'b0, req}, {27'b0, L});
    pop_one("b2b_h1", L);
    pop_one("b2b_t1", L);
    chk("b2b_dead", {27'b0, req}, 0);
    @(posedge clk); #1;
    chk("b2b_req_w", {27'b0, req}, {27'b0, W});
    pop_one("b2b_h2", W);
    pop_one("b2b_t2", W);
    chk("b2b_end", {27'b0, req}, 0);

    // Orphan body flit after reset
    do_reset();
    send_flit(body(400), 0);
    @(posedge clk); #1;
`ifdef IBUF_DROP_ORPHAN_EN
    chk("orphan_dropped", {31'b0, empty}, 1);
    chk("orphan_err", {31'b0, err}, 1);
    send_flit(hdr(2'd1, 2'd0, 401), 1);
    @(posedge clk); #1;
    chk("orphan_next_route", {27'b0, req}, {27'b0, N});
    send_flit(tail(402), 1);
    pop_one("orphan_h", N);
    pop_one("orphan_t", N);
    chk("orphan_err_sticky", {31'b0, err}, 1);
`else
    @(posedge clk); #1;
    chk("orphan_held", {31'b0, empty}, 0);
    chk("orphan_no_req", {27'b0, req}, 0);
    chk("orphan_no_err", {31'b0, err}, 0);
    chk("orphan_data", Data_out, body(400));
`endif
    do_reset();

    // Reset mid-packet while BUSY with two flits buffered
    send_flit(hdr(2'd1, 2'd2, 500), 1);
    send_flit(body(501), 1);
    @(posedge clk); #1;
    chk("mid_busy_req", {27'b0, req}, {27'b0, S});
    rst = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_empty", {31'b0, empty}, 1);
    chk("mid_rst_req",   {27'b0, req}, 0);
    chk("mid_rst_cts",   {31'b0, CTS}, 0);
    chk("mid_rst_err",   {31'b0, err}, 0);
    rst = 1'b1;
    sb.delete();
    @(posedge clk); #1;
    chk("post_rst_idle", {27'b0, req}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
